ctrl_reg_mc: RTL and testbench
==============================

# ctrl_reg_mc

Parametrised multi-channel control/status register file for the MCDF datapath. Sits between the external command port and the per-channel slaves/arbiter, holding per-channel enable, priority and packet length, exposing live slave FIFO margin as read-only status, and returning read data through a registered, valid-qualified response. Generalises the fixed 3-channel register block to NUM_CH channels and adds registered read-valid signalling plus optional sticky access-error reporting.

## Interface
- NUM_CH, 3, number of slave channels (1..8)
- ADDR_W, 8, command byte-address width (≥7)
- MARGIN_W, 8, slave margin width (≤32)
- CTRL_RST, 32'h0000_0007, reset value of every control register (en=1, prio=3, pkglen=0)

- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- cmd_i  in  2  00 idle, 01 read, 10 write, 11 illegal
- cmd_addr_i  in  ADDR_W  byte address
- cmd_data_i  in  32  write data
- cmd_data_o  out  32  read data, registered
- cmd_rvalid_o  out  1  one-cycle pulse, cmd_data_o valid
- slv_margin_i  in  NUM_CH*MARGIN_W  per-channel margin, channel n at [n*MARGIN_W +: MARGIN_W]
- slv_en_o  out  NUM_CH  per-channel enable
- slv_prio_o  out  NUM_CH*2  per-channel priority, 0 highest
- slv_pkglen_o  out  NUM_CH*3  per-channel packet-length code
- err_o  out  1  OR of error register bits (0 when CTRL_REG_ERR_EN undefined)

## Operation
- Map: CTRL[n] at 0x00+4n (RW); STAT[n] at 0x20+4n (RO); ERR at 0x40 (RW1C, macro only); all else unmapped.
- CTRL fields: [0] en, [2:1] prio, [5:3] pkglen, [31:6] reserved, ignore on write, read 0.
- STAT: [MARGIN_W-1:0] = slv_margin_i of channel n sampled on the read cycle; upper bits 0.
- Write (10): mapped CTRL updated at that posedge; writes to STAT/unmapped discarded.
- Read (01): cmd_data_o and cmd_rvalid_o=1 registered at that posedge; unmapped returns 0. cmd_data_o holds last value until next read.
- Idle/illegal: no state change except ERR; cmd_rvalid_o=0.
- Address bits [1:0] ignored for decode.
- ERR bits (sticky): [0] write to RO/unmapped, [1] read unmapped, [2] cmd 11, [3] addr[1:0]≠0. Write-1 clears; set in same cycle as clear wins.

## Timing
- Reset: CTRL[n]=CTRL_RST, so slv_en_o all 1, slv_prio_o all 2'b11, slv_pkglen_o all 0; cmd_data_o=0; cmd_rvalid_o=0; ERR=0; err_o=0.
- Write-to-output latency 1 cycle (outputs are direct register bits).
- Read latency 1 cycle; back-to-back reads give one response per cycle, rvalid stays high.
- Read of CTRL[n] the cycle after a write to it returns the new value.
- Reset asserted mid-operation clears everything immediately; a read in flight produces no rvalid.
- err_o combinational from ERR register, so rises the cycle after the offending command.

## Configuration
- CTRL_REG_ERR_EN defined: ERR register, error detection and err_o implemented as above.
- Undefined: no ERR logic; 0x40 is unmapped (reads 0); err_o tied 0; illegal/unaligned commands silently ignored.

## Structure
- Package ctrl_reg_pkg: cmd enum (CMD_IDLE, CMD_RD, CMD_WR, CMD_ILL), CTRL_BASE/STAT_BASE/ERR_ADDR offsets, CTRL field LSB/width constants, ERR bit indices.
- Sub-module ctrl_reg_ch: one channel's CTRL register with write-enable and field outputs, generated NUM_CH times; decode, read mux and ERR in top.

## Test plan
- Reset, NUM_CH=3: after rstn_i rise, slv_en_o=3'b111, slv_prio_o=6'b111111, slv_pkglen_o=0; read 0x04 -> rvalid next cycle, data 0x07.
- Write 0x08 data 0x3F then read 0x08 next cycle -> data 0x3F, slv_en_o[2]=1, prio 3, pkglen 7; write 0xFFFF_FFC0 -> reads 0x00.
- slv_margin_i ch1=20; read 0x24 -> data 0x14; back-to-back reads 0x20,0x24,0x28 -> three consecutive rvalid cycles, data 10,20,30.
- Read 0x30 (unmapped) -> data 0, rvalid 1; with CTRL_REG_ERR_EN ERR=0x2, err_o=1; write 0x40 data 0x2 -> ERR=0, err_o=0.
- cmd 11 and write to 0x21 -> CTRL unchanged, ERR=0x0D (macro) / err_o=0 (no macro).
- Assert rstn_i low in the cycle after a write to 0x00 with 0x00 -> CTRL[0] back to 0x07, no rvalid.

Source files
------------

// File: rtl/ctrl_reg_pkg.sv
// Shared definitions for the MCDF control/status register file: command
// encodings, register map offsets, CTRL field layout and ERR bit positions.
package ctrl_reg_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE = 2'b00,
    CMD_RD   = 2'b01,
    CMD_WR   = 2'b10,
    CMD_ILL  = 2'b11
  } cmd_e;

  localparam logic [7:0] CTRL_BASE = 8'h00;
  localparam logic [7:0] STAT_BASE = 8'h20;
  localparam logic [7:0] ERR_ADDR  = 8'h40;

  localparam int EN_BIT     = 0;
  localparam int PRIO_LSB   = 1;
  localparam int PRIO_W     = 2;
  localparam int PKGLEN_LSB = 3;
  localparam int PKGLEN_W   = 3;
  localparam int CTRL_W     = 6;

  localparam int ERR_WR_RO     = 0;
  localparam int ERR_RD_UNMAP  = 1;
  localparam int ERR_ILL_CMD   = 2;
  localparam int ERR_UNALIGNED = 3;
  localparam int ERR_W         = 4;

endpackage

// File: rtl/ctrl_reg_ch.sv
// One channel's CTRL register. Only the implemented field bits are stored;
// reserved bits are dropped on write and read back as zero in the top.
module ctrl_reg_ch
  import ctrl_reg_pkg::*;
#(
  parameter logic [CTRL_W-1:0] RST_VAL = 6'h07
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                wr_en_i,
  input  logic [CTRL_W-1:0]   wr_data_i,
  output logic [CTRL_W-1:0]   ctrl_o,
  output logic                en_o,
  output logic [PRIO_W-1:0]   prio_o,
  output logic [PKGLEN_W-1:0] pkglen_o
);

  logic [CTRL_W-1:0] ctrl_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ctrl_q <= RST_VAL;
    end else if (wr_en_i) begin
      ctrl_q <= wr_data_i;
    end
  end

  assign ctrl_o   = ctrl_q;
  assign en_o     = ctrl_q[EN_BIT];
  assign prio_o   = ctrl_q[PRIO_LSB +: PRIO_W];
  assign pkglen_o = ctrl_q[PKGLEN_LSB +: PKGLEN_W];

endmodule

// File: rtl/ctrl_reg_mc.sv
// Multi-channel control/status register file with registered read response.
// Define CTRL_REG_ERR_EN to add the sticky RW1C error register at 0x40 and err_o.
module ctrl_reg_mc
  import ctrl_reg_pkg::*;
#(
  parameter int          NUM_CH   = 3,
  parameter int          ADDR_W   = 8,
  parameter int          MARGIN_W = 8,
  parameter logic [31:0] CTRL_RST = 32'h0000_0007
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic [1:0]                   cmd_i,
  input  logic [ADDR_W-1:0]            cmd_addr_i,
  input  logic [31:0]                  cmd_data_i,
  output logic [31:0]                  cmd_data_o,
  output logic                         cmd_rvalid_o,
  input  logic [NUM_CH*MARGIN_W-1:0]   slv_margin_i,
  output logic [NUM_CH-1:0]            slv_en_o,
  output logic [NUM_CH*PRIO_W-1:0]     slv_prio_o,
  output logic [NUM_CH*PKGLEN_W-1:0]   slv_pkglen_o,
  output logic                         err_o
);

  cmd_e              cmd;
  logic              is_rd;
  logic              is_wr;
  logic [ADDR_W-6:0] blk;
  logic [2:0]        ch_idx;
  logic              ch_valid;
  logic              ctrl_hit;
  logic              stat_hit;
  logic              err_hit;
  logic [31:0]       err_rd_val;
  logic [31:0]       rd_data;
  logic [CTRL_W-1:0] ctrl_q [NUM_CH];

  assign cmd   = cmd_e'(cmd_i);
  assign is_rd = (cmd == CMD_RD);
  assign is_wr = (cmd == CMD_WR);

  // Address decodes on 32-byte blocks; the low two byte bits never select a register.
  assign blk      = cmd_addr_i[ADDR_W-1:5];
  assign ch_idx   = cmd_addr_i[4:2];
  assign ch_valid = ({1'b0, ch_idx} < 4'(NUM_CH));
  assign ctrl_hit = (blk == (ADDR_W-5)'(CTRL_BASE >> 5)) && ch_valid;
  assign stat_hit = (blk == (ADDR_W-5)'(STAT_BASE >> 5)) && ch_valid;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    ctrl_reg_ch #(
      .RST_VAL(CTRL_RST[CTRL_W-1:0])
    ) u_ch (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .wr_en_i  (is_wr && ctrl_hit && (ch_idx == 3'(n))),
      .wr_data_i(cmd_data_i[CTRL_W-1:0]),
      .ctrl_o   (ctrl_q[n]),
      .en_o     (slv_en_o[n]),
      .prio_o   (slv_prio_o[n*PRIO_W +: PRIO_W]),
      .pkglen_o (slv_pkglen_o[n*PKGLEN_W +: PKGLEN_W])
    );
  end

`ifdef CTRL_REG_ERR_EN
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_set;
  logic [ERR_W-1:0] err_clr;
  logic             unused_bits;

  assign err_hit = (blk == (ADDR_W-5)'(ERR_ADDR >> 5)) && (ch_idx == ERR_ADDR[4:2]);

  always_comb begin
    err_set                = '0;
    err_set[ERR_WR_RO]     = is_wr && !ctrl_hit && !err_hit;
    err_set[ERR_RD_UNMAP]  = is_rd && !(ctrl_hit || stat_hit || err_hit);
    err_set[ERR_ILL_CMD]   = (cmd == CMD_ILL);
    err_set[ERR_UNALIGNED] = (is_rd || is_wr) && (cmd_addr_i[1:0] != 2'b00);
    err_clr                = (is_wr && err_hit) ? cmd_data_i[ERR_W-1:0] : '0;
  end

  // A new error arriving alongside its clear must not be lost, so set wins.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      err_q <= '0;
    end else begin
      err_q <= (err_q & ~err_clr) | err_set;
    end
  end

  assign err_o       = |err_q;
  assign err_rd_val  = 32'(err_q);
  assign unused_bits = ^cmd_data_i[31:CTRL_W];
`else
  logic unused_bits;

  assign err_hit     = 1'b0;
  assign err_o       = 1'b0;
  assign err_rd_val  = '0;
  assign unused_bits = ^{cmd_data_i[31:CTRL_W], cmd_addr_i[1:0]};
`endif

  always_comb begin
    rd_data = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (ctrl_hit && (ch_idx == 3'(n))) begin
        rd_data = 32'(ctrl_q[n]);
      end
      if (stat_hit && (ch_idx == 3'(n))) begin
        rd_data = 32'(slv_margin_i[n*MARGIN_W +: MARGIN_W]);
      end
    end
    if (err_hit) begin
      rd_data = err_rd_val;
    end
  end

  // Read data is held between reads so a slow consumer can sample it late.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cmd_data_o   <= '0;
      cmd_rvalid_o <= 1'b0;
    end else begin
      cmd_rvalid_o <= is_rd;
      if (is_rd) begin
        cmd_data_o <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_ctrl_reg_mc.sv
// Directed bench for ctrl_reg_mc (NUM_CH=3); ERR expectations follow
// whether CTRL_REG_ERR_EN is defined for the build.
module tb_ctrl_reg_mc;

  localparam int NUM_CH   = 3;
  localparam int ADDR_W   = 8;
  localparam int MARGIN_W = 8;

  logic                       clk_i;
  logic                       rstn_i;
  logic [1:0]                 cmd_i;
  logic [ADDR_W-1:0]          cmd_addr_i;
  logic [31:0]                cmd_data_i;
  logic [31:0]                cmd_data_o;
  logic                       cmd_rvalid_o;
  logic [NUM_CH*MARGIN_W-1:0] slv_margin_i;
  logic [NUM_CH-1:0]          slv_en_o;
  logic [NUM_CH*2-1:0]        slv_prio_o;
  logic [NUM_CH*3-1:0]        slv_pkglen_o;
  logic                       err_o;

  int checks   = 0;
  int failures = 0;

  ctrl_reg_mc #(
    .NUM_CH  (NUM_CH),
    .ADDR_W  (ADDR_W),
    .MARGIN_W(MARGIN_W),
    .CTRL_RST(32'h0000_0007)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .cmd_i       (cmd_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_data_i  (cmd_data_i),
    .cmd_data_o  (cmd_data_o),
    .cmd_rvalid_o(cmd_rvalid_o),
    .slv_margin_i(slv_margin_i),
    .slv_en_o    (slv_en_o),
    .slv_prio_o  (slv_prio_o),
    .slv_pkglen_o(slv_pkglen_o),
    .err_o       (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [1:0] c, input logic [7:0] a, input logic [31:0] d);
    cmd_i      = c;
    cmd_addr_i = a;
    cmd_data_i = d;
  endtask

  task automatic test_reset();
    rstn_i       = 1'b0;
    slv_margin_i = {8'd30, 8'd20, 8'd10};
    drive(2'b00, 8'h00, 32'h0);
    repeat (3) @(posedge clk_i);
    #1;
    checks++; if (slv_en_o !== 3'b111) begin failures++; $display("[TB] FAIL reset_en got=%b exp=%b", slv_en_o, 3'b111); end
    checks++; if (slv_prio_o !== 6'b111111) begin failures++; $display("[TB] FAIL reset_prio got=%b exp=%b", slv_prio_o, 6'b111111); end
    checks++; if (slv_pkglen_o !== 9'h000) begin failures++; $display("[TB] FAIL reset_pkglen got=%h exp=%h", slv_pkglen_o, 9'h000); end
    checks++; if (cmd_data_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_data got=%h exp=%h", cmd_data_o, 32'h0); end
    checks++; if (cmd_rvalid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_rvalid got=%b exp=0", cmd_rvalid_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", err_o); end
    rstn_i = 1'b1;
    tick();
    drive(2'b01, 8'h04, 32'h0);
    tick();
    checks++; if (cmd_rvalid_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_rd_rvalid got=%b exp=1", cmd_rvalid_o); end
    checks++; if (cmd_data_o !== 32'h7) begin failures++; $display("[TB] FAIL reset_rd_data got=%h exp=%h", cmd_data_o, 32'h7); end
    drive(2'b00, 8'h00, 32'h0);
    tick();
    checks++; if (cmd_rvalid_o !== 1'b0) begin failures++; $display("[TB] FAIL rvalid_pulse got=%b exp=0", cmd_rvalid_o); end
    checks++; if (cmd_data_o !== 32'h7) begin failures++; $display("[TB] FAIL data_hold got=%h exp=%h", cmd_data_o, 32'h7); end
  endtask

  task automatic test_write_read();
    drive(2'b10, 8'h08, 32'h0000_003F);
    tick();
    checks++; if (slv_en_o !== 3'b111) begin failures++; $display("[TB] FAIL wr_en got=%b exp=%b", slv_en_o, 3'b111); end
    checks++; if (slv_prio_o !== 6'b111111) begin failures++; $display("[TB] FAIL wr_prio got=%b exp=%b", slv_prio_o, 6'b111111); end
    checks++; if (slv_pkglen_o !== 9'h1C0) begin failures++; $display("[TB] FAIL wr_pkglen got=%h exp=%h", slv_pkglen_o, 9'h1C0); end
    drive(2'b01, 8'h08, 32'h0);
    tick();
    checks++; if (cmd_data_o !== 32'h3F) begin failures++; $display("[TB] FAIL wr_readback got=%h exp=%h", cmd_data_o, 32'h3F); end
    drive(2'b10, 8'h08, 32'hFFFF_FFC0);
    tick();
    checks++; if (slv_en_o !== 3'b011) begin failures++; $display("[TB] FAIL rsvd_en got=%b exp=%b", slv_en_o, 3'b011); end
    checks++; if (slv_prio_o !== 6'b001111) begin failures++; $display("[TB] FAIL rsvd_prio got=%b exp=%b", slv_prio_o, 6'b001111); end
    checks++; if (slv_pkglen_o !== 9'h000) begin failures++; $display("[TB] FAIL rsvd_pkglen got=%h exp=%h", slv_pkglen_o, 9'h000); end
    drive(2'b01, 8'h08, 32'h0);
    tick();
    checks++; if (cmd_data_o !== 32'h0) begin failures++; $display("[TB] FAIL rsvd_readback got=%h exp=%h", cmd_data_o, 32'h0); end
    checks++; if (cmd_rvalid_o !== 1'b1) begin failures++; $display("[TB] FAIL rsvd_rvalid got=%b exp=1", cmd_rvalid_o); end
    drive(2'b00, 8'h00, 32'h0);
    tick();
  endtask

  task automatic test_status();
    drive(2'b01, 8'h24, 32'h0);
    tick();
    checks++; if (cmd_data_o !== 32'h14) begin failures++; $display("[TB] FAIL stat1 got=%h exp=%h", cmd_data_o, 32'h14); end
    drive(2'b01, 8'h20, 32'h0);
    tick();
    checks++; if (cmd_rvalid_o !== 1'b1 || cmd_data_o !== 32'd10) begin failures++; $display("[TB] FAIL b2b_0 got=%b/%h exp=1/%h", cmd_rvalid_o, cmd_data_o, 32'd10); end
    drive(2'b01, 8'h24, 32'h0);
    tick();
    checks++; if (cmd_rvalid_o !== 1'b1 || cmd_data_o !== 32'd20) begin failures++; $display("[TB] FAIL b2b_1 got=%b/%h exp=1/%h", cmd_rvalid_o, cmd_data_o, 32'd20); end
    drive(2'b01, 8'h28, 32'h0);
    tick();
    checks++; if (cmd_rvalid_o !== 1'b1 || cmd_data_o !== 32'd30) begin failures++; $display("[TB] FAIL b2b_2 got=%b/%h exp=1/%h", cmd_rvalid_o, cmd_data_o, 32'd30); end
    drive(2'b00, 8'h00, 32'h0);
    slv_margin_i = {8'd99, 8'd20, 8'd10};
    tick();
    checks++; if (cmd_rvalid_o !== 1'b0 || cmd_data_o !== 32'd30) begin failures++; $display("[TB] FAIL stat_hold got=%b/%h exp=0/%h", cmd_rvalid_o, cmd_data_o, 32'd30); end
  endtask

  task automatic test_unmapped();
    logic        exp_err;
    logic [31:0] exp_err_reg;
`ifdef CTRL_REG_ERR_EN
    exp_err     = 1'b1;
    exp_err_reg = 32'h2;
`else
    exp_err     = 1'b0;
    exp_err_reg = 32'h0;
`endif
    drive(2'b01, 8'h30, 32'h0);
    tick();
    checks++; if (cmd_rvalid_o !== 1'b1 || cmd_data_o !== 32'h0) begin failures++; $display("[TB] FAIL unmap_rd got=%b/%h exp=1/0", cmd_rvalid_o, cmd_data_o); end
    checks++; if (err_o !== exp_err) begin failures++; $display("[TB] FAIL unmap_err got=%b exp=%b", err_o, exp_err); end
    drive(2'b01, 8'h04, 32'h0);
    tick();
    drive(2'b01, 8'h0C, 32'h0);
    tick();
    checks++; if (cmd_data_o !== 32'h0) begin failures++; $display("[TB] FAIL ch3_absent got=%h exp=0", cmd_data_o); end
    drive(2'b01, 8'h40, 32'h0);
    tick();
    checks++; if (cmd_data_o !== exp_err_reg) begin failures++; $display("[TB] FAIL err_reg_rd got=%h exp=%h", cmd_data_o, exp_err_reg); end
    drive(2'b10, 8'h40, 32'h2);
    tick();
    checks++; if (err_o !== 1'b0) begin failures++; $display("[TB] FAIL err_clear got=%b exp=0", err_o); end
    drive(2'b00, 8'h00, 32'h0);
    tick();
  endtask

  task automatic test_illegal();
    logic        exp_err;
    logic [31:0] exp_err_reg;
`ifdef CTRL_REG_ERR_EN
    exp_err     = 1'b1;
    exp_err_reg = 32'h0D;
`else
    exp_err     = 1'b0;
    exp_err_reg = 32'h0;
`endif
    drive(2'b11, 8'h00, 32'h0);
    tick();
    checks++; if (cmd_rvalid_o !== 1'b0) begin failures++; $display("[TB] FAIL ill_rvalid got=%b exp=0", cmd_rvalid_o); end
    drive(2'b10, 8'h21, 32'h0);
    tick();
    checks++; if (slv_en_o !== 3'b011 || slv_prio_o !== 6'b001111) begin failures++; $display("[TB] FAIL ill_ctrl got=%b/%b exp=011/001111", slv_en_o, slv_prio_o); end
    checks++; if (err_o !== exp_err) begin failures++; $display("[TB] FAIL ill_err got=%b exp=%b", err_o, exp_err); end
    drive(2'b01, 8'h00, 32'h0);
    tick();
    checks++; if (cmd_data_o !== 32'h7) begin failures++; $display("[TB] FAIL ill_ctrl0 got=%h exp=%h", cmd_data_o, 32'h7); end
    drive(2'b01, 8'h40, 32'h0);
    tick();
    checks++; if (cmd_data_o !== exp_err_reg) begin failures++; $display("[TB] FAIL ill_err_reg got=%h exp=%h", cmd_data_o, exp_err_reg); end
    drive(2'b10, 8'h40, 32'hF);
    tick();
    drive(2'b00, 8'h00, 32'h0);
    tick();
  endtask

  task automatic test_reset_mid();
    drive(2'b10, 8'h00, 32'h0);
    tick();
    checks++; if (slv_en_o !== 3'b010 || slv_prio_o !== 6'b001100) begin failures++; $display("[TB] FAIL mid_wr got=%b/%b exp=010/001100", slv_en_o, slv_prio_o); end
    drive(2'b01, 8'h00, 32'h0);
    #2;
    rstn_i = 1'b0;
    #1;
    checks++; if (slv_en_o !== 3'b111 || slv_prio_o !== 6'b111111) begin failures++; $display("[TB] FAIL mid_rst_ctrl got=%b/%b exp=111/111111", slv_en_o, slv_prio_o); end
    checks++; if (cmd_data_o !== 32'h0) begin failures++; $display("[TB] FAIL mid_rst_data got=%h exp=0", cmd_data_o); end
    tick();
    checks++; if (cmd_rvalid_o !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_rvalid got=%b exp=0", cmd_rvalid_o); end
    drive(2'b00, 8'h00, 32'h0);
    rstn_i = 1'b1;
    tick();
    drive(2'b01, 8'h00, 32'h0);
    tick();
    checks++; if (cmd_rvalid_o !== 1'b1 || cmd_data_o !== 32'h7) begin failures++; $display("[TB] FAIL mid_rst_rd got=%b/%h exp=1/%h", cmd_rvalid_o, cmd_data_o, 32'h7); end
    drive(2'b00, 8'h00, 32'h0);
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_status();
    test_unmapped();
    test_illegal();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
